unidade_acesso_memoria: RTL and testbench



---
 rtl/pkg_mem.sv | 76 +++++++
 rtl/alinhador_carga.sv | 13 +
 rtl/unidade_acesso_memoria.sv | 198 +++++++++++++++++++
 tb/tb_unidade_acesso_memoria.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkg_mem.sv
// Shared definitions for the load/store unit: op codes, FSM states,
// the response bundle, and lane extract/merge helpers.
package pkg_mem;

    localparam int unsigned LARG_PALAVRA = 32;
    localparam int unsigned LARG_RD      = 5;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        OCIOSO      = 3'd0,
        ACESSO      = 3'd1,
        LEITURA_RMW = 3'd2,
        ESCRITA_RMW = 3'd3,
        RESPOSTA    = 3'd4
    } estado_e;

    typedef struct packed {
        logic [LARG_PALAVRA-1:0] dado;
        logic [LARG_RD-1:0]      rd;
        logic                    escreve_reg;
        logic                    erro;
    } resposta_t;

    function automatic logic eh_carga(input op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    // Select the addressed lane of a read word and sign/zero-extend it.
    function automatic logic [31:0] extrair_carga(input logic [31:0] palavra,
                                                  input op_e         op,
                                                  input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(palavra >> {lane, 3'b000});
        h = 16'(palavra >> {lane[1], 4'b0000});
        case (op)
            OP_LW:   r = palavra;
            OP_LH:   r = {{16{h[15]}}, h};
            OP_LHU:  r = {16'h0000, h};
            OP_LB:   r = {{24{b[7]}}, b};
            OP_LBU:  r = {24'h000000, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    // Little-endian merge of a byte/half store into the old word.
    function automatic logic [31:0] mesclar_escrita(input logic [31:0] palavra,
                                                    input logic [15:0] dado,
                                                    input op_e         op,
                                                    input logic [1:0]  lane);
        logic [31:0] mascara;
        logic [31:0] valor;
        if (op == OP_SB) begin
            mascara = 32'h0000_00FF << {lane, 3'b000};
            valor   = {24'h000000, dado[7:0]} << {lane, 3'b000};
        end else begin
            mascara = 32'h0000_FFFF << {lane[1], 4'b0000};
            valor   = {16'h0000, dado} << {lane[1], 4'b0000};
        end
        return (palavra & ~mascara) | (valor & mascara);
    endfunction

endpackage

// File: rtl/alinhador_carga.sv
// Combinational load aligner: picks the addressed byte/half and extends it.
module alinhador_carga
    import pkg_mem::*;
(
    input  logic [31:0] palavra,
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    output logic [31:0] dado_c
);

    assign dado_c = extrair_carga(palavra, op_e'(op), lane);

endmodule

// File: rtl/unidade_acesso_memoria.sv
// MEM-stage load/store initiator: one transaction at a time, RMW for
// sub-word stores, registered memory strobes and WB response.
module unidade_acesso_memoria
    import pkg_mem::*;
#(
    parameter int unsigned PROFUNDIDADE = 32,
    parameter int unsigned LARG_IDX     = 5
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        ent_valido,
    output logic        ent_pronto,
    input  logic [2:0]  ent_op,
    input  logic [31:0] ent_endereco,
    input  logic [31:0] ent_dado,
    input  logic [4:0]  ent_rd,
    output logic [31:0] mem_endereco,
    output logic [31:0] mem_valor,
    output logic        mem_escrever,
    output logic        mem_ler,
    input  logic [31:0] mem_dado_lido,
    output logic        sai_valido,
    input  logic        sai_pronto,
    output logic [31:0] sai_dado,
    output logic [4:0]  sai_rd,
    output logic        sai_escreve_reg,
    output logic        sai_erro
);

    localparam logic [31:0] LIMITE = 32'(4 * PROFUNDIDADE);

    estado_e             estado, estado_nxt;
    op_e                 op_q, op_nxt;
    logic [LARG_IDX-1:0] idx_q, idx_nxt;
    logic [1:0]          lane_q, lane_nxt;
    logic [15:0]         dado_q, dado_nxt;
    logic [4:0]          rd_q, rd_nxt;
    resposta_t           resp_q, resp_nxt;
    logic                valido_q, valido_nxt;
    logic                pronto_q, pronto_nxt;
    logic                ler_q, ler_nxt;
    logic                esc_q, esc_nxt;
    logic [31:0]         end_q, end_nxt;
    logic [31:0]         valor_q, valor_nxt;

    op_e                 op_ent_c;
    logic                erro_ent_c;
    logic [31:0]         extraido_c;

    assign op_ent_c = op_e'(ent_op);

    // Alignment and range check on the incoming request.
    always_comb begin
        erro_ent_c = 1'b0;
        case (op_ent_c)
            OP_LW, OP_SW:          erro_ent_c = (ent_endereco[1:0] != 2'b00);
            OP_LH, OP_LHU, OP_SH:  erro_ent_c = ent_endereco[0];
            default:               erro_ent_c = 1'b0;
        endcase
        if (ent_endereco >= LIMITE) begin
            erro_ent_c = 1'b1;
        end
    end

    alinhador_carga u_alinhador (
        .palavra (mem_dado_lido),
        .op      (op_q),
        .lane    (lane_q),
        .dado_c  (extraido_c)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= OCIOSO;
            op_q     <= OP_LW;
            idx_q    <= '0;
            lane_q   <= '0;
            dado_q   <= '0;
            rd_q     <= '0;
            resp_q   <= '0;
            valido_q <= 1'b0;
            pronto_q <= 1'b1;
            ler_q    <= 1'b0;
            esc_q    <= 1'b0;
            end_q    <= '0;
            valor_q  <= '0;
        end else begin
            estado   <= estado_nxt;
            op_q     <= op_nxt;
            idx_q    <= idx_nxt;
            lane_q   <= lane_nxt;
            dado_q   <= dado_nxt;
            rd_q     <= rd_nxt;
            resp_q   <= resp_nxt;
            valido_q <= valido_nxt;
            pronto_q <= pronto_nxt;
            ler_q    <= ler_nxt;
            esc_q    <= esc_nxt;
            end_q    <= end_nxt;
            valor_q  <= valor_nxt;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        estado_nxt = estado;
        op_nxt     = op_q;
        idx_nxt    = idx_q;
        lane_nxt   = lane_q;
        dado_nxt   = dado_q;
        rd_nxt     = rd_q;
        resp_nxt   = resp_q;
        valido_nxt = valido_q;
        pronto_nxt = 1'b0;
        ler_nxt    = 1'b0;
        esc_nxt    = 1'b0;
        end_nxt    = '0;
        valor_nxt  = '0;

        case (estado)
            OCIOSO: begin
                pronto_nxt = 1'b1;
                if (ent_valido && pronto_q) begin
                    pronto_nxt = 1'b0;
                    op_nxt     = op_ent_c;
                    idx_nxt    = ent_endereco[LARG_IDX+1:2];
                    lane_nxt   = ent_endereco[1:0];
                    dado_nxt   = ent_dado[15:0];
                    rd_nxt     = ent_rd;
                    if (erro_ent_c) begin
                        estado_nxt = RESPOSTA;
                        valido_nxt = 1'b1;
                        resp_nxt   = '{dado: 32'h0, rd: ent_rd, escreve_reg: 1'b0, erro: 1'b1};
                    end else if ((op_ent_c == OP_SB) || (op_ent_c == OP_SH)) begin
                        estado_nxt = LEITURA_RMW;
                        ler_nxt    = 1'b1;
                        end_nxt    = 32'(ent_endereco[LARG_IDX+1:2]);
                    end else begin
                        estado_nxt = ACESSO;
                        end_nxt    = 32'(ent_endereco[LARG_IDX+1:2]);
                        if (op_ent_c == OP_SW) begin
                            esc_nxt   = 1'b1;
                            valor_nxt = ent_dado;
                        end else begin
                            ler_nxt = 1'b1;
                        end
                    end
                end
            end
            ACESSO: begin
                estado_nxt = RESPOSTA;
                valido_nxt = 1'b1;
                resp_nxt   = '{dado:        eh_carga(op_q) ? extraido_c : 32'h0,
                               rd:          rd_q,
                               escreve_reg: eh_carga(op_q),
                               erro:        1'b0};
            end
            LEITURA_RMW: begin
                estado_nxt = ESCRITA_RMW;
                esc_nxt    = 1'b1;
                end_nxt    = 32'(idx_q);
                valor_nxt  = mesclar_escrita(mem_dado_lido, dado_q, op_q, lane_q);
            end
            ESCRITA_RMW: begin
                estado_nxt = RESPOSTA;
                valido_nxt = 1'b1;
                resp_nxt   = '{dado: 32'h0, rd: rd_q, escreve_reg: 1'b0, erro: 1'b0};
            end
            RESPOSTA: begin
                if (sai_pronto) begin
                    estado_nxt = OCIOSO;
                    pronto_nxt = 1'b1;
                    valido_nxt = 1'b0;
                    resp_nxt   = '0;
                end
            end
            default: begin
                estado_nxt = OCIOSO;
                pronto_nxt = 1'b1;
                valido_nxt = 1'b0;
                resp_nxt   = '0;
            end
        endcase
    end

    assign ent_pronto      = pronto_q;
    assign mem_endereco    = end_q;
    assign mem_valor       = valor_q;
    assign mem_ler         = ler_q;
    assign mem_escrever    = esc_q;
    assign sai_valido      = valido_q;
    assign sai_dado        = resp_q.dado;
    assign sai_rd          = resp_q.rd;
    assign sai_escreve_reg = resp_q.escreve_reg;
    assign sai_erro        = resp_q.erro;

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Bench for unidade_acesso_memoria: directed table, reset corner cases and
// random traffic against a byte-addressed reference memory.
module tb_unidade_acesso_memoria;

    localparam int PROF = 32;
    localparam int NBYTES = 4 * PROF;

    logic        clock = 1'b0;
    logic        reset;
    logic        ent_valido;
    logic        ent_pronto;
    logic [2:0]  ent_op;
    logic [31:0] ent_endereco;
    logic [31:0] ent_dado;
    logic [4:0]  ent_rd;
    logic [31:0] mem_endereco;
    logic [31:0] mem_valor;
    logic        mem_escrever;
    logic        mem_ler;
    logic [31:0] mem_dado_lido;
    logic        sai_valido;
    logic        sai_pronto;
    logic [31:0] sai_dado;
    logic [4:0]  sai_rd;
    logic        sai_escreve_reg;
    logic        sai_erro;

    int checks = 0;
    int errors = 0;

    logic [31:0] memoria [PROF] = '{default: 32'h0};
    logic [7:0]  ref_mem [NBYTES] = '{default: 8'h0};

    unidade_acesso_memoria #(.PROFUNDIDADE(32), .LARG_IDX(5)) dut (
        .clock           (clock),
        .reset           (reset),
        .ent_valido      (ent_valido),
        .ent_pronto      (ent_pronto),
        .ent_op          (ent_op),
        .ent_endereco    (ent_endereco),
        .ent_dado        (ent_dado),
        .ent_rd          (ent_rd),
        .mem_endereco    (mem_endereco),
        .mem_valor       (mem_valor),
        .mem_escrever    (mem_escrever),
        .mem_ler         (mem_ler),
        .mem_dado_lido   (mem_dado_lido),
        .sai_valido      (sai_valido),
        .sai_pronto      (sai_pronto),
        .sai_dado        (sai_dado),
        .sai_rd          (sai_rd),
        .sai_escreve_reg (sai_escreve_reg),
        .sai_erro        (sai_erro)
    );

    always #5 clock = ~clock;

    // Data memory block: combinational read, write on the rising edge.
    always @(posedge clock) begin
        if (mem_escrever && (mem_endereco < 32'(PROF))) memoria[mem_endereco[4:0]] <= mem_valor;
    end
    assign mem_dado_lido = (mem_ler && (mem_endereco < 32'(PROF))) ? memoria[mem_endereco[4:0]] : 32'hDEAD_BEEF;

    task automatic verificar(input string nome, input logic [31:0] obtido, input logic [31:0] esperado);
        checks++;
        if (obtido !== esperado) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nome, obtido, esperado);
        end
    endtask

    // One full transaction; expectations come from the byte-level reference memory.
    task automatic transacao(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] dado,
                             input logic [4:0] rd, input int atraso,
                             output logic [31:0] o_dado, output logic o_erro, output logic o_esc);
        int tam, a, base, esp_lat, esp_ler, esp_escm;
        int ciclos, n_ler, n_esc, n_ambos, n_pronto;
        logic carga, erro, timeout;
        logic [31:0] esp_dado, esp_palavra;

        carga = (op <= 3'd4);
        case (op)
            3'd0, 3'd5:       tam = 4;
            3'd1, 3'd2, 3'd6: tam = 2;
            default:          tam = 1;
        endcase
        erro = ((addr % 32'(tam)) != 32'd0) || (addr >= 32'(NBYTES));
        a = int'(addr);
        esp_dado = 32'h0;
        esp_palavra = 32'h0;
        if (!erro && carga) begin
            for (int i = 0; i < tam; i++) esp_dado = esp_dado | (32'(ref_mem[a+i]) << (8*i));
            if (op == 3'd1 && esp_dado[15]) esp_dado[31:16] = 16'hFFFF;
            if (op == 3'd3 && esp_dado[7])  esp_dado[31:8]  = 24'hFFFFFF;
        end
        if (!erro && !carga) begin
            for (int i = 0; i < tam; i++) ref_mem[a+i] = 8'(dado >> (8*i));
            base = a - (a % 4);
            esp_palavra = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        end
        esp_lat  = erro ? 1 : ((op == 3'd6 || op == 3'd7) ? 3 : 2);
        esp_ler  = (!erro && op != 3'd5) ? 1 : 0;
        esp_escm = (!erro && !carga) ? 1 : 0;

        ciclos = 0;
        while (!ent_pronto && ciclos < 10) begin
            @(negedge clock);
            ciclos++;
        end
        verificar("ent_pronto idle", 32'(ent_pronto), 32'd1);
        sai_pronto   = (atraso == 0);
        ent_valido   = 1'b1;
        ent_op       = op;
        ent_endereco = addr;
        ent_dado     = dado;
        ent_rd       = rd;
        @(negedge clock);
        ent_valido   = 1'b0;
        ent_op       = 3'($urandom);
        ent_endereco = $urandom;
        ent_dado     = $urandom;
        ent_rd       = 5'($urandom);

        ciclos = 1; n_ler = 0; n_esc = 0; n_ambos = 0; n_pronto = 0; timeout = 1'b0;
        while (1) begin
            if (mem_ler || mem_escrever) verificar("mem_endereco", mem_endereco, addr >> 2);
            if (mem_escrever) verificar("mem_valor", mem_valor, esp_palavra);
            if (mem_ler) n_ler++;
            if (mem_escrever) n_esc++;
            if (mem_ler && mem_escrever) n_ambos++;
            if (ent_pronto) n_pronto++;
            if (sai_valido) break;
            if (ciclos >= 10) begin
                timeout = 1'b1;
                break;
            end
            @(negedge clock);
            ciclos++;
        end
        o_dado = sai_dado;
        o_erro = sai_erro;
        o_esc  = sai_escreve_reg;
        if (timeout) begin
            verificar("timeout sai_valido", 32'd0, 32'd1);
            sai_pronto = 1'b1;
            repeat (3) @(negedge clock);
            sai_pronto = 1'b0;
            return;
        end
        verificar("latencia", 32'(ciclos), 32'(esp_lat));
        verificar("n_ler", 32'(n_ler), 32'(esp_ler));
        verificar("n_escrever", 32'(n_esc), 32'(esp_escm));
        verificar("strobes juntos", 32'(n_ambos), 32'd0);
        verificar("ent_pronto ocupado", 32'(n_pronto), 32'd0);
        verificar("sai_dado", sai_dado, esp_dado);
        verificar("sai_erro", 32'(sai_erro), 32'(erro));
        verificar("sai_escreve_reg", 32'(sai_escreve_reg), 32'(carga && !erro));
        if (carga && !erro) verificar("sai_rd", 32'(sai_rd), 32'(rd));

        for (int k = 0; k < atraso; k++) begin
            @(negedge clock);
            verificar("hold sai_valido", 32'(sai_valido), 32'd1);
            verificar("hold sai_dado", sai_dado, esp_dado);
            verificar("hold sai_erro", 32'(sai_erro), 32'(erro));
            verificar("hold ent_pronto", 32'(ent_pronto), 32'd0);
            verificar("hold strobes", 32'({mem_ler, mem_escrever}), 32'd0);
        end
        sai_pronto = 1'b1;
        @(negedge clock);
        verificar("pos handshake sai_valido", 32'(sai_valido), 32'd0);
        verificar("pos handshake ent_pronto", 32'(ent_pronto), 32'd1);
        sai_pronto = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] dado;
        logic [4:0]  rd;
        int          atraso;
        logic [31:0] esp_dado;
        logic        esp_erro;
        logic        esp_esc;
    } vetor_t;

    vetor_t tabela [13];

    initial begin
        logic [31:0] o_dado;
        logic        o_erro, o_esc;
        logic [2:0]  op;
        logic [31:0] addr;
        int          r;

        tabela[0]  = '{3'd5, 32'h0C, 32'h8899AABB, 5'd1,  0, 32'h00000000, 1'b0, 1'b0};
        tabela[1]  = '{3'd3, 32'h0E, 32'h0,        5'd7,  0, 32'hFFFFFF99, 1'b0, 1'b1};
        tabela[2]  = '{3'd4, 32'h0E, 32'h0,        5'd8,  0, 32'h00000099, 1'b0, 1'b1};
        tabela[3]  = '{3'd2, 32'h0E, 32'h0,        5'd9,  0, 32'h00008899, 1'b0, 1'b1};
        tabela[4]  = '{3'd1, 32'h0E, 32'h0,        5'd10, 1, 32'hFFFF8899, 1'b0, 1'b1};
        tabela[5]  = '{3'd7, 32'h0D, 32'h00000011, 5'd2,  0, 32'h00000000, 1'b0, 1'b0};
        tabela[6]  = '{3'd0, 32'h0C, 32'h0,        5'd11, 3, 32'h889911BB, 1'b0, 1'b1};
        tabela[7]  = '{3'd1, 32'h0D, 32'h0,        5'd12, 0, 32'h00000000, 1'b1, 1'b0};
        tabela[8]  = '{3'd0, 32'h80, 32'h0,        5'd13, 2, 32'h00000000, 1'b1, 1'b0};
        tabela[9]  = '{3'd6, 32'h02, 32'h1234ABCD, 5'd3,  0, 32'h00000000, 1'b0, 1'b0};
        tabela[10] = '{3'd0, 32'h00, 32'h0,        5'd14, 0, 32'hABCD0000, 1'b0, 1'b1};
        tabela[11] = '{3'd3, 32'h7F, 32'h0,        5'd15, 0, 32'h00000000, 1'b0, 1'b1};
        tabela[12] = '{3'd5, 32'h7D, 32'h55555555, 5'd4,  0, 32'h00000000, 1'b1, 1'b0};

        reset = 1'b1; ent_valido = 1'b0; ent_op = 3'd0; ent_endereco = 32'h0;
        ent_dado = 32'h0; ent_rd = 5'd0; sai_pronto = 1'b0;
        repeat (3) @(negedge clock);
        verificar("reset ent_pronto", 32'(ent_pronto), 32'd1);
        verificar("reset sai_valido", 32'(sai_valido), 32'd0);
        verificar("reset mem_ler", 32'(mem_ler), 32'd0);
        verificar("reset mem_escrever", 32'(mem_escrever), 32'd0);
        verificar("reset mem_endereco", mem_endereco, 32'h0);
        verificar("reset sai_dado", sai_dado, 32'h0);
        verificar("reset sai_erro", 32'(sai_erro), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 13; i++) begin
            transacao(tabela[i].op, tabela[i].addr, tabela[i].dado, tabela[i].rd, tabela[i].atraso,
                      o_dado, o_erro, o_esc);
            verificar($sformatf("tabela[%0d] dado", i), o_dado, tabela[i].esp_dado);
            verificar($sformatf("tabela[%0d] erro", i), 32'(o_erro), 32'(tabela[i].esp_erro));
            verificar($sformatf("tabela[%0d] escreve", i), 32'(o_esc), 32'(tabela[i].esp_esc));
        end

        // Reset while the SB read half is in flight: memory must keep the old word.
        transacao(3'd5, 32'h20, 32'h11223344, 5'd1, 0, o_dado, o_erro, o_esc);
        ent_valido = 1'b1; ent_op = 3'd7; ent_endereco = 32'h21; ent_dado = 32'h55; ent_rd = 5'd2;
        @(negedge clock);
        ent_valido = 1'b0;
        verificar("rmw leitura mem_ler", 32'(mem_ler), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        verificar("reset leitura strobes", 32'({mem_ler, mem_escrever}), 32'd0);
        verificar("reset leitura ent_pronto", 32'(ent_pronto), 32'd1);
        repeat (2) begin
            @(negedge clock);
            verificar("pos reset sem escrita", 32'(mem_escrever), 32'd0);
        end
        transacao(3'd0, 32'h20, 32'h0, 5'd5, 0, o_dado, o_erro, o_esc);
        verificar("palavra intacta", o_dado, 32'h11223344);

        // Reset during the SB write half.
        ent_valido = 1'b1; ent_op = 3'd7; ent_endereco = 32'h21; ent_dado = 32'h55; ent_rd = 5'd2;
        @(negedge clock);
        ent_valido = 1'b0;
        @(negedge clock);
        verificar("rmw escrita mem_escrever", 32'(mem_escrever), 32'd1);
        verificar("rmw escrita mem_valor", mem_valor, 32'h11225544);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        verificar("reset escrita strobes", 32'({mem_ler, mem_escrever}), 32'd0);
        verificar("reset escrita sai_valido", 32'(sai_valido), 32'd0);
        verificar("reset escrita ent_pronto", 32'(ent_pronto), 32'd1);
        repeat (2) begin
            @(negedge clock);
            verificar("pos reset escrita sem strobe", 32'({mem_ler, mem_escrever}), 32'd0);
        end
        transacao(3'd5, 32'h20, 32'h11223344, 5'd1, 0, o_dado, o_erro, o_esc);

        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = 32'($urandom_range(0, NBYTES - 1));
            else begin
                addr = 32'($urandom_range(0, NBYTES - 1));
                if (op == 3'd0 || op == 3'd5) addr[1:0] = 2'b00;
                else if (op == 3'd1 || op == 3'd2 || op == 3'd6) addr[0] = 1'b0;
            end
            transacao(op, addr, $urandom, 5'($urandom), int'($urandom_range(0, 2)), o_dado, o_erro, o_esc);
        end

        for (int w = 0; w < PROF; w++) begin
            verificar($sformatf("memoria[%0d]", w), memoria[w],
                      {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
